// File: rtl/pix_unpack_pkg.sv
// rtl/pix_unpack_pkg.sv - shared constants and IDLE/ACTIVE state encoding for pix_unpack
package pix_unpack_pkg;

   localparam int VRAM_WORD_W   = 128;
   localparam int BYTE_PER_WORD = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Number of output pixel groups carried by one VRAM word.
   function automatic int lanes_per_word(input int out_w);
      return VRAM_WORD_W / out_w;
   endfunction

endpackage

// File: rtl/pix_unpack_fifo.sv
// rtl/pix_unpack_fifo.sv - synchronous word buffer with occupancy count and flush
module pix_unpack_fifo #(
   parameter  int WIDTH = 128,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;

   assign w_full  = (r_count == CW'(DEPTH));
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign w_wr    = wr_en && !w_full;
   assign w_rd    = rd_en && !empty;
   // Head word comes straight out of the storage registers, so a word
   // written at one edge is visible for the whole following cycle.
   assign rd_data = r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end

   // Word storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/pix_unpack.sv
// rtl/pix_unpack.sv - VRAM word to pixel-group unpacker; PIX_UNPACK_UNDERRUN_CNT_EN adds underrun_count
module pix_unpack
   import pix_unpack_pkg::*;
#(
   parameter int OUT_W      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   vsync,
   input  logic [23:0]            frame_bytes,
   input  logic [VRAM_WORD_W-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   underrun,
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
   output logic [15:0]            underrun_count,
`endif
   output logic                   overflow
);

   localparam int LANES      = lanes_per_word(OUT_W);
   localparam int LANE_W     = $clog2(LANES);
   localparam int BEAT_BYTES = OUT_W / 8;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [LANE_W-1:0]        r_lane;
   logic [23:0]              r_byte_cnt;
   logic [23:0]              r_frame_bytes;
   logic                     r_underrun;
   logic                     r_overflow;

   logic [VRAM_WORD_W-1:0]   w_head;
   logic [CW-1:0]            w_fifo_count;
   logic                     w_fifo_empty;
   logic                     w_in_ready;
   logic                     w_out_valid;
   logic                     w_last;
   logic                     w_last_lane;
   logic                     w_beat;
   logic                     w_start;
   logic                     w_starve;
   logic                     w_restart;
   logic                     w_flush;
   logic                     w_take;
   logic                     w_wr;
   logic                     w_rd;

   assign w_start     = vsync && enable;
   assign w_in_ready  = (r_state == ACTIVE) && (w_fifo_count < CW'(FIFO_DEPTH));
   assign w_out_valid = (r_state == ACTIVE) && !w_fifo_empty;
   assign w_last      = (r_byte_cnt == r_frame_bytes - 24'(BEAT_BYTES));
   assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
   assign w_beat      = w_out_valid && out_ready;
   assign w_starve    = (r_state == ACTIVE) && out_ready && !w_out_valid;
   assign w_rd        = w_take && w_last_lane;

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_head[int'(r_lane)*OUT_W +: OUT_W];
   assign out_last  = w_out_valid && w_last;
   assign underrun  = r_underrun;
   assign overflow  = r_overflow;

   pix_unpack_fifo #(
      .WIDTH (VRAM_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (w_flush),
      .wr_en   (w_wr),
      .wr_data (in_data),
      .rd_en   (w_rd),
      .rd_data (w_head),
      .count   (w_fifo_count),
      .empty   (w_fifo_empty)
   );

   // Frame state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and per-cycle control; a restart outranks every other event.
   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_flush     = 1'b0;
      w_take      = 1'b0;
      w_wr        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = ACTIVE;
               w_restart   = 1'b1;
               w_flush     = 1'b1;
            end
         end
         ACTIVE: begin
            if (w_start) begin
               w_restart = 1'b1;
               w_flush   = 1'b1;
            end else if (!enable || (r_frame_bytes == '0)) begin
               w_state_nxt = IDLE;
               w_flush     = 1'b1;
            end else begin
               w_wr   = in_valid && w_in_ready;
               w_take = w_beat;
               if (w_beat && w_last) begin
                  w_state_nxt = IDLE;
                  w_flush     = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_flush     = 1'b1;
         end
      endcase
   end

   // Lane, byte counter, latched frame size and sticky status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lane        <= '0;
         r_byte_cnt    <= '0;
         r_frame_bytes <= '0;
         r_underrun    <= 1'b0;
         r_overflow    <= 1'b0;
      end else if (w_restart) begin
         r_lane        <= '0;
         r_byte_cnt    <= '0;
         r_frame_bytes <= frame_bytes;
         r_underrun    <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_take) begin
            r_lane     <= w_last_lane ? '0 : r_lane + LANE_W'(1);
            r_byte_cnt <= r_byte_cnt + 24'(BEAT_BYTES);
         end
         if (w_starve)               r_underrun <= 1'b1;
         if (in_valid && !w_in_ready) r_overflow <= 1'b1;
      end
   end

`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   assign underrun_count = r_underrun_cnt;

   // Saturating count of starved cycles, cleared on restart.
   always_ff @(posedge clk) begin
      if (!rst_n || w_restart)                      r_underrun_cnt <= '0;
      else if (w_starve && (r_underrun_cnt != '1)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_pix_unpack.sv
// tb/tb_pix_unpack.sv - self-checking bench for pix_unpack (OUT_W=32, FIFO_DEPTH=4)
module tb_pix_unpack;

   localparam int OUT_W = 32;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic         vsync;
   logic [23:0]  frame_bytes;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         underrun;
   logic         overflow;
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
   logic [15:0]  underrun_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pix_unpack #(.OUT_W(OUT_W), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .vsync          (vsync),
      .frame_bytes    (frame_bytes),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .underrun       (underrun),
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
      .underrun_count (underrun_count),
`endif
      .overflow       (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic start_frame(input int fb);
      vsync = 1'b1; enable = 1'b1; frame_bytes = 24'(fb);
      step();
      vsync = 1'b0;
   endtask

   // Word whose byte b equals base+b.
   function automatic logic [127:0] ramp_word(input int base);
      logic [127:0] w;
      for (int b = 0; b < 16; b++) w[8*b +: 8] = 8'(base + b);
      return w;
   endfunction

   // Streams one already-started frame, checking each beat against the byte stream.
   task automatic stream(input int fb, input int pv, input int pr);
      logic [7:0]   bytes[$];
      logic [127:0] w;
      logic [31:0]  exp_d;
      int nwords = fb / 16;
      int nbeats = fb / 4;
      int sent = 0;
      int k = 0;
      int cyc = 0;
      bytes = {};
      while (k < nbeats && cyc < 3000) begin
         if (in_ready && sent < nwords && $urandom_range(0, 99) < pv) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            in_data  = w;
            for (int b = 0; b < 16; b++) bytes.push_back(w[8*b +: 8]);
            sent++;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 99) < pr);
         #1;
         if (out_valid && out_ready) begin
            for (int b = 0; b < 4; b++) exp_d[8*b +: 8] = bytes[4*k + b];
            n_checks++;
            if (out_data !== exp_d || out_last !== (k == nbeats - 1)) begin
               n_fail++;
               $display("FAIL stream_beat %0d: data %h last %b expected %h %b",
                        k, out_data, out_last, exp_d, (k == nbeats - 1));
            end
            k++;
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (k != nbeats) begin
         n_fail++;
         $display("FAIL stream_timeout: got %0d beats expected %0d", k, nbeats);
      end
      chk("stream_idle_valid", 64'(out_valid), 64'd0);
      chk("stream_idle_ready", 64'(in_ready), 64'd0);
      chk("stream_no_overflow", 64'(overflow), 64'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; frame_bytes = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
      chk("reset_out_last", 64'(out_last), 64'd0);
      chk("reset_underrun", 64'(underrun), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
      chk("reset_underrun_count", 64'(underrun_count), 64'd0);
`endif
   endtask

   task automatic test_first_word_and_overflow();
      logic [31:0] exp_d;
      start_frame(64);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = ramp_word(0);
      step();
      in_valid = 1'b0;
      chk("first_out_valid", 64'(out_valid), 64'd1);
      chk("first_out_data", 64'(out_data), 64'h03020100);
      for (int i = 1; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = ramp_word(16 * i);
         step();
      end
      in_valid = 1'b0;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = {4{32'hDEADBEEF}};
      step();
      in_valid = 1'b0;
      chk("overflow_set", 64'(overflow), 64'd1);
      chk("stall_data_stable", 64'(out_data), 64'h03020100);
      chk("stall_last_low", 64'(out_last), 64'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         for (int b = 0; b < 4; b++) exp_d[8*b +: 8] = 8'(4*k + b);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (k == 15)) begin
            n_fail++;
            $display("FAIL drain_beat %0d: valid %b data %h last %b expected 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d, (k == 15));
         end
         step();
      end
      out_ready = 1'b0;
      chk("drain_idle_valid", 64'(out_valid), 64'd0);
      chk("drain_idle_ready", 64'(in_ready), 64'd0);
      chk("overflow_sticky", 64'(overflow), 64'd1);
   endtask

   task automatic test_underrun();
      start_frame(64);
      out_ready = 1'b1;
      step(); step(); step();
      out_ready = 1'b0;
      chk("underrun_set", 64'(underrun), 64'd1);
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
      chk("underrun_count3", 64'(underrun_count), 64'd3);
`endif
      start_frame(64);
      chk("underrun_cleared", 64'(underrun), 64'd0);
      chk("overflow_cleared", 64'(overflow), 64'd0);
`ifdef PIX_UNPACK_UNDERRUN_CNT_EN
      chk("underrun_count_cleared", 64'(underrun_count), 64'd0);
`endif
      enable = 1'b0;
      step();
      enable = 1'b1;
   endtask

   task automatic test_vsync_restart();
      start_frame(64);
      in_valid = 1'b1;
      in_data  = ramp_word(100);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step(); step();
      chk("restart_pre_valid", 64'(out_valid), 64'd1);
      vsync = 1'b1; frame_bytes = 24'd16;
      step();
      vsync = 1'b0;
      out_ready = 1'b0;
      chk("restart_flushed", 64'(out_valid), 64'd0);
      chk("restart_active", 64'(in_ready), 64'd1);
      stream(16, 100, 100);
   endtask

   task automatic test_zero_frame();
      start_frame(0);
      chk("zero_no_valid", 64'(out_valid), 64'd0);
      step();
      chk("zero_idle_ready", 64'(in_ready), 64'd0);
      chk("zero_idle_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic test_enable_low();
      start_frame(64);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = ramp_word(32 * i);
         step();
      end
      in_valid = 1'b0;
      enable   = 1'b0;
      step();
      chk("enlow_valid", 64'(out_valid), 64'd0);
      chk("enlow_ready", 64'(in_ready), 64'd0);
      enable = 1'b1;
      step(); step();
      chk("enlow_stays_idle", 64'(out_valid), 64'd0);
   endtask

   task automatic test_reset_mid_frame();
      start_frame(64);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = ramp_word(16 * i);
         step();
      end
      in_valid = 1'b0;
      chk("rstmid_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rstmid_valid", 64'(out_valid), 64'd0);
      chk("rstmid_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      step(); step(); step();
      out_ready = 1'b0;
      chk("rstmid_no_beat", 64'(out_valid), 64'd0);
      start_frame(32);
      stream(32, 100, 100);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 5; f++) begin
         int fb;
         fb = 16 * $urandom_range(1, 8);
         start_frame(fb);
         stream(fb, $urandom_range(30, 100), $urandom_range(30, 100));
      end
   endtask

   initial begin
      test_reset();
      test_first_word_and_overflow();
      test_underrun();
      test_vsync_restart();
      test_zero_frame();
      test_enable_low();
      test_reset_mid_frame();
      test_random_frames();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
